// File: rtl/uid_restore_if.sv
// Handshake bundle between the unique-ID allocator / slave response path and uid_restore.
interface uid_restore_if #(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 16
);
  localparam int IDX_W = $clog2(MAX_OUTSTANDING);
  localparam int UID_W = 2 * IDX_W;

  logic                alloc_valid;
  logic                alloc_ready;
  logic [UID_W-1:0]    alloc_uid;
  logic [ID_WIDTH-1:0] alloc_id;

  logic                rsp_in_valid;
  logic                rsp_in_ready;
  logic [UID_W-1:0]    rsp_in_uid;
  logic                rsp_in_last;

  logic                rsp_out_valid;
  logic                rsp_out_ready;
  logic [ID_WIDTH-1:0] rsp_out_id;
  logic                rsp_out_last;

  logic                release_valid;
  logic [IDX_W-1:0]    release_row;

  modport slave (
    input  alloc_valid, alloc_uid, alloc_id,
    output alloc_ready,
    input  rsp_in_valid, rsp_in_uid, rsp_in_last,
    output rsp_in_ready,
    output rsp_out_valid, rsp_out_id, rsp_out_last,
    input  rsp_out_ready,
    output release_valid, release_row
  );

  modport master (
    output alloc_valid, alloc_uid, alloc_id,
    input  alloc_ready,
    output rsp_in_valid, rsp_in_uid, rsp_in_last,
    input  rsp_in_ready,
    input  rsp_out_valid, rsp_out_id, rsp_out_last,
    output rsp_out_ready,
    input  release_valid, release_row
  );
endinterface

// File: rtl/uid_restore.sv
// Restores original AXI IDs on R/B responses tagged with {row,col} unique IDs,
// frees entries on last beats and reports rows that become empty.
module uid_restore #(
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  uid_restore_if.slave               bus,
  output logic [MAX_OUTSTANDING-1:0] row_busy,
  output logic                       err_unknown,
  output logic                       err_id_mismatch
);
  localparam int N     = MAX_OUTSTANDING;
  localparam int IDX_W = $clog2(N);
  localparam int UID_W = 2 * IDX_W;

  logic [N-1:0]        busy_q   [N];
  logic [N-1:0]        busy_d   [N];
  logic [IDX_W:0]      cnt_q    [N];
  logic [IDX_W:0]      cnt_d    [N];
  logic [ID_WIDTH-1:0] row_id_q [N];

  logic [IDX_W-1:0]    a_row, a_col, r_row, r_col;
  logic                a_busy, a_conflict, alloc_fire;
  logic                r_busy, rsp_fire, free_fire, last_free;

  logic                vld_p1;
  logic [ID_WIDTH-1:0] id_p1;
  logic                last_p1;
  logic                rel_vld_p1;
  logic [IDX_W-1:0]    rel_row_p1;

  assign a_row = bus.alloc_uid[UID_W-1:IDX_W];
  assign a_col = bus.alloc_uid[IDX_W-1:0];
  assign r_row = bus.rsp_in_uid[UID_W-1:IDX_W];
  assign r_col = bus.rsp_in_uid[IDX_W-1:0];

  assign a_busy          = busy_q[a_row][a_col];
  assign a_conflict      = (cnt_q[a_row] != '0) && (row_id_q[a_row] != bus.alloc_id);
  assign bus.alloc_ready = !rst && !a_busy && !a_conflict;
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;

  assign r_busy           = busy_q[r_row][r_col];
  assign bus.rsp_in_ready = !rst && (!vld_p1 || bus.rsp_out_ready);
  assign rsp_fire         = bus.rsp_in_valid && bus.rsp_in_ready;
  assign free_fire        = rsp_fire && bus.rsp_in_last && r_busy;
  // A row empties only when its single entry is freed and nothing lands in it this cycle.
  assign last_free        = free_fire && (cnt_q[r_row] == (IDX_W+1)'(1)) &&
                            !(alloc_fire && (a_row == r_row));

  always_comb begin
    for (int r = 0; r < N; r++) begin
      busy_d[r] = busy_q[r];
      cnt_d[r]  = cnt_q[r];
      if (alloc_fire && (a_row == IDX_W'(r))) begin
        busy_d[r][a_col] = 1'b1;
        cnt_d[r]         = cnt_d[r] + 1'b1;
      end
      if (free_fire && (r_row == IDX_W'(r))) begin
        busy_d[r][r_col] = 1'b0;
        cnt_d[r]         = cnt_d[r] - 1'b1;
      end
    end
  end

  always_comb begin
    row_busy = '0;
    for (int r = 0; r < N; r++) begin
      row_busy[r] = (cnt_q[r] != '0);
    end
  end

  // Stage p0 -> p1: entry table update and registered response / release outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        busy_q[r]   <= '0;
        cnt_q[r]    <= '0;
        row_id_q[r] <= '0;
      end
      err_unknown     <= 1'b0;
      err_id_mismatch <= 1'b0;
      vld_p1          <= 1'b0;
      id_p1           <= '0;
      last_p1         <= 1'b0;
      rel_vld_p1      <= 1'b0;
      rel_row_p1      <= '0;
    end else begin
      for (int r = 0; r < N; r++) begin
        busy_q[r] <= busy_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
      if (alloc_fire && (cnt_q[a_row] == '0)) begin
        row_id_q[a_row] <= bus.alloc_id;
      end
      if (bus.alloc_valid && a_conflict) begin
        err_id_mismatch <= 1'b1;
      end
      if (rsp_fire && !r_busy) begin
        err_unknown <= 1'b1;
      end
      if (rsp_fire) begin
        vld_p1  <= 1'b1;
        id_p1   <= row_id_q[r_row];
        last_p1 <= bus.rsp_in_last;
      end else if (bus.rsp_out_ready) begin
        vld_p1  <= 1'b0;
      end
      rel_vld_p1 <= last_free;
      if (last_free) begin
        rel_row_p1 <= r_row;
      end
    end
  end

  assign bus.rsp_out_valid = vld_p1;
  assign bus.rsp_out_id    = id_p1;
  assign bus.rsp_out_last  = last_p1;
  assign bus.release_valid = rel_vld_p1;
  assign bus.release_row   = rel_row_p1;
endmodule
